// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with configurable word width, slave-select count,
// all four CPOL/CPHA modes, and a per-transfer SCK divider and target select.
//
// Ports:
//   clk, rst        - system clock and asynchronous active-low reset
//   start           - transfer request; sampled only while idle
//   tx_data         - word to send, shifted out MSB first
//   slave_sel       - index of the target to select
//   cpol, cpha      - SPI mode for the transfer
//   clk_div         - SCK half-period, in clk cycles, minus one
//   miso            - serial data from the target
//   sck, mosi       - SPI clock and serial data to the target
//   ss_n            - active-low selects, one low while a transfer runs
//   rx_data         - last received word; updated when done pulses
//   busy, done, err - in-progress flag, completion pulse, rejected-start pulse
module spi_master_multi #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  slave_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Toggle counter must hold 0 .. 2*DATA_W.
    localparam int unsigned EW = $clog2(2 * DATA_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              lead, trail;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= '1;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        lead      = 1'b0;
        trail     = 1'b0;

        case (state_q)
            S_IDLE: begin
                sck_d = cpol;
                if (start) begin
                    if (32'(slave_sel) < NUM_SS) begin
                        state_d = S_SETUP;
                        cnt_d   = '0;
                        edge_d  = '0;
                        div_d   = clk_div;
                        tx_d    = tx_data;
                        cpol_d  = cpol;
                        cpha_d  = cpha;
                        rx_sh_d = '0;
                        busy_d  = 1'b1;
                        ss_n_d  = ~(NUM_SS'(1) << slave_sel);
                        // Mode with cpha=0 presents the MSB before the first edge.
                        if (!cpha) begin
                            mosi_d = tx_data[DATA_W-1];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SETUP, S_XFER: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (edge_q == EW'(2 * DATA_W)) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_XFER;
                        edge_d  = edge_q + EW'(1);
                        sck_d   = ~sck_q;
                        // Toggle number edge_q+1: odd ones lead, even ones trail.
                        lead    = ~edge_q[0];
                        trail   = edge_q[0];
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            S_HOLD: begin
                if (cnt_q == div_q) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    ss_n_d    = '1;
                    rx_data_d = rx_sh_q;
                    sck_d     = cpol_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Sample on leading edges for cpha=0, trailing edges for cpha=1.
        if (cpha_q ? trail : lead) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
        end
        if (cpha_q && lead) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
        end
        // cpha=0 shifts on trailing edges; the final trailing edge has no next bit.
        if (!cpha_q && trail && (edge_q != EW'(2 * DATA_W - 1))) begin
            mosi_d = tx_q[DATA_W-2];
            tx_d   = tx_q << 1;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: SPI target model, scoreboard of expected words,
// latency / select / edge checks per transfer.
module tb_spi_master_multi;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_SS = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DIV_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic [SEL_W-1:0]  slave_sel = '0;
    logic              cpol = 1'b0;
    logic              cpha = 1'b0;
    logic [DIV_W-1:0]  clk_div = '0;
    logic              miso;
    logic              sck;
    logic              mosi;
    logic [NUM_SS-1:0] ss_n;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              err;

    spi_master_multi #(
        .DATA_W(DATA_W), .NUM_SS(NUM_SS), .SEL_W(SEL_W), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .slave_sel(slave_sel), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
        .miso(miso), .sck(sck), .mosi(mosi), .ss_n(ss_n), .rx_data(rx_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SPI target model: acts half a clk after each SCK change.
    logic [7:0] sl_word = '0;
    logic [7:0] sl_sh = '0;
    logic [7:0] sl_rx = '0;
    logic       sl_cpol = 1'b0;
    logic       sl_cpha = 1'b0;
    logic       sl_miso = 1'b0;
    logic       sl_act = 1'b0;
    logic       sl_sck = 1'b0;
    logic       loop = 1'b0;
    logic       sl_now;
    logic       sl_lead;

    assign miso = loop ? mosi : sl_miso;

    always @(negedge clk) begin
        sl_now = (ss_n != 4'hF);
        if (sl_now && !sl_act) begin
            sl_sh = sl_word;
            sl_rx = '0;
            if (!sl_cpha) sl_miso = sl_sh[7];
        end else if (sl_now && (sck != sl_sck)) begin
            sl_lead = (sck != sl_cpol);
            if (sl_lead == !sl_cpha) begin
                sl_rx = {sl_rx[6:0], mosi};
            end else if (!sl_cpha) begin
                sl_sh   = sl_sh << 1;
                sl_miso = sl_sh[7];
            end else begin
                sl_miso = sl_sh[7];
                sl_sh   = sl_sh << 1;
            end
        end
        sl_act = sl_now;
        sl_sck = sck;
    end

    // Scoreboard: expected master rx word and expected word seen by the target.
    typedef struct packed {
        logic [7:0] rx;
        logic [7:0] mo;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (done) begin
            if (expq.size() == 0) begin
                check_eq("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = expq.pop_front();
                check_eq("rx_data", 32'(rx_data), 32'(mon_e.rx));
                check_eq("target_rx", 32'(sl_rx), 32'(mon_e.mo));
            end
        end
    end

    // Drive a start at the current time; returns #1 after the sampling edge.
    task automatic launch(input logic [2:0] sel, input logic [7:0] tx, input logic pol,
                          input logic pha, input logic [7:0] div, input logic [7:0] sword,
                          input logic lp);
        exp_t e;
        slave_sel = sel; tx_data = tx; cpol = pol; cpha = pha; clk_div = div;
        sl_word = sword; sl_cpol = pol; sl_cpha = pha; loop = lp;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        e.rx = lp ? tx : sword;
        e.mo = tx;
        expq.push_back(e);
    endtask

    // Watch a transfer until done; optional start/input disturbance at cycle inj.
    task automatic wait_done(input logic [3:0] exp_ss, input logic pol, input logic pha,
                             input int lat, input int inj);
        int   rises = 0;
        int   ss_bad = 0;
        int   edge_bad = 0;
        int   err_seen = 0;
        bit   seen = 0;
        logic sp;
        logic mp;
        sp = sck;
        mp = mosi;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (n == inj) begin
                start = 1'b1; tx_data = ~tx_data; slave_sel = 3'd1; clk_div = 8'd0;
            end else if (n == inj + 1) begin
                start = 1'b0;
            end
            if (ss_n !== exp_ss || busy !== 1'b1) ss_bad++;
            if (err) err_seen++;
            if (sck && !sp) rises++;
            if (mosi !== mp && !(sck !== sp && ((sck != pol) == pha))) edge_bad++;
            sp = sck;
            mp = mosi;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        if (seen) begin
            check_eq("latency", 32'(cyc - t0), 32'(lat));
            check_eq("ss_n_busy", 32'(ss_bad), 32'd0);
            check_eq("sck_rises", 32'(rises), 32'd8);
            check_eq("mosi_edges", 32'(edge_bad), 32'd0);
            check_eq("no_err", 32'(err_seen), 32'd0);
            check_eq("ss_n_done", 32'(ss_n), 32'hF);
            check_eq("busy_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sck"}, 32'(sck), 32'd0);
        check_eq({tag, "_mosi"}, 32'(mosi), 32'd0);
        check_eq({tag, "_ss_n"}, 32'(ss_n), 32'hF);
        check_eq({tag, "_rx"}, 32'(rx_data), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, loopback, divide by 2 half-period.
        launch(3'd0, 8'hA5, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1);
        wait_done(4'hE, 1'b0, 1'b0, 36, -10);

        // Mode 3, fastest SCK.
        @(negedge clk);
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("sck_idle_cpol1", 32'(sck), 32'd1);
        launch(3'd0, 8'h3C, 1'b1, 1'b1, 8'd0, 8'hC3, 1'b0);
        wait_done(4'hE, 1'b1, 1'b1, 18, -10);

        // Modes 1 and 2 on target 2.
        @(negedge clk);
        launch(3'd2, 8'h81, 1'b0, 1'b1, 8'd3, 8'h7E, 1'b0);
        wait_done(4'hB, 1'b0, 1'b1, 72, -10);
        @(negedge clk);
        launch(3'd2, 8'h81, 1'b1, 1'b0, 8'd3, 8'h7E, 1'b0);
        wait_done(4'hB, 1'b1, 1'b0, 72, -10);

        // Out-of-range select is rejected with a one-cycle err.
        @(negedge clk);
        slave_sel = 3'd5; cpol = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("err_pulse", 32'(err), 32'd1);
        check_eq("err_busy", 32'(busy), 32'd0);
        check_eq("err_ss_n", 32'(ss_n), 32'hF);
        @(posedge clk);
        #1;
        check_eq("err_one_cycle", 32'(err), 32'd0);
        check_eq("err_still_idle", 32'(busy), 32'd0);

        // Reset in the middle of a transfer.
        @(negedge clk);
        launch(3'd1, 8'h33, 1'b0, 1'b0, 8'd1, 8'hCC, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        expq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("post_rst_idle", 32'(busy), 32'd0);

        // Transfer after reset release.
        launch(3'd0, 8'h5A, 1'b0, 1'b0, 8'd0, 8'h96, 1'b0);
        wait_done(4'hE, 1'b0, 1'b0, 18, -10);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        launch(3'd3, 8'hC6, 1'b0, 1'b0, 8'd1, 8'h39, 1'b0);
        wait_done(4'h7, 1'b0, 1'b0, 36, 5);
        launch(3'd0, 8'h5E, 1'b0, 1'b0, 8'd1, 8'hA1, 1'b0);
        check_eq("b2b_ss_n", 32'(ss_n), 32'hE);
        wait_done(4'hE, 1'b0, 1'b0, 36, -10);

        // Maximum divider.
        @(negedge clk);
        launch(3'd3, 8'hD2, 1'b0, 1'b1, 8'd255, 8'h4B, 1'b0);
        wait_done(4'h7, 1'b0, 1'b1, 18 * 256, -10);

        repeat (3) @(negedge clk);
        check_eq("queue_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
